// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped L1 data cache.
package dcache_pkg;
  localparam int LINE_OFFSET_W = 4;
  localparam int WORD_SEL_W    = 3;

  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } dcache_state_t;
endpackage

// File: rtl/dcache_array.sv
// Per-set line, tag, valid and dirty storage. Byte-enabled synchronous write,
// combinational read; reset clears only valid/dirty.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IW       = $clog2(NUM_SETS),
  parameter int TW       = 12 - IW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  index_i,
  input  logic [15:0]    be_i,
  input  lc3b_cache_line wline_i,
  input  logic           load_i,
  input  logic [TW-1:0]  tag_i,
  input  logic           dirty_set_i,
  output lc3b_cache_line line_o,
  output logic [TW-1:0]  tag_o,
  output logic           valid_o,
  output logic           dirty_o
);
  lc3b_cache_line      data_q [NUM_SETS];
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 16; b++) begin
      if (be_i[b]) data_q[index_i][8*b +: 8] <= wline_i[8*b +: 8];
    end
    if (load_i) tag_q[index_i] <= tag_i;
  end

  // A fresh fill always lands clean, even if the set was dirty before.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (dirty_set_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  assign line_o  = data_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with zero-wait-state hits.
// Optional hit/miss counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           read_b,
  input  logic           write_b,
  input  logic [1:0]     wmask_b,
  input  logic [15:0]    address_b,
  input  logic [15:0]    wdata_b,
  output logic           resp_b,
  output logic [15:0]    rdata_b,
  output logic           pmem_read,
  output logic           pmem_write,
  output logic [15:0]    pmem_address,
  output lc3b_cache_line pmem_wdata,
  input  lc3b_cache_line pmem_rdata,
  input  logic           pmem_resp,
  output logic [15:0]    hit_count,
  output logic [15:0]    miss_count
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  dcache_state_t         state_q;
  logic                  pmem_read_q, pmem_write_q;
  logic [15:0]           pmem_address_q;

  logic [IW-1:0]         index;
  logic [TW-1:0]         tag, tag_o;
  logic [WORD_SEL_W-1:0] word;
  lc3b_cache_line        line, wline;
  logic [15:0]           be;
  logic                  valid, dirty, hit, req, wr_hit, fill;
  logic                  unused_addr;

  assign index       = address_b[LINE_OFFSET_W+IW-1:LINE_OFFSET_W];
  assign tag         = address_b[15:LINE_OFFSET_W+IW];
  assign word        = address_b[LINE_OFFSET_W-1:1];
  assign unused_addr = address_b[0];

  assign req    = read_b | write_b;
  assign hit    = valid && (tag_o == tag);
  assign resp_b = (state_q == IDLE) && req && hit;
  assign rdata_b = resp_b ? line[{word, 4'b0000} +: 16] : 16'h0000;
  assign wr_hit = resp_b && write_b && (|wmask_b);
  assign fill   = (state_q == ALLOCATE) && pmem_resp && !reset;

  // wdata_b is replicated into every word lane; the byte enables pick the target.
  always_comb begin
    be    = '0;
    wline = {8{wdata_b}};
    if (fill) begin
      be    = '1;
      wline = pmem_rdata;
    end else if (wr_hit) begin
      be[{word, 1'b0}] = wmask_b[0];
      be[{word, 1'b1}] = wmask_b[1];
    end
  end

  dcache_array #(.NUM_SETS(NUM_SETS), .IW(IW), .TW(TW)) u_array (
    .clk        (clk),
    .reset      (reset),
    .index_i    (index),
    .be_i       (be),
    .wline_i    (wline),
    .load_i     (fill),
    .tag_i      (tag),
    .dirty_set_i(wr_hit),
    .line_o     (line),
    .tag_o      (tag_o),
    .valid_o    (valid),
    .dirty_o    (dirty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (valid && dirty) begin
              state_q        <= WRITEBACK;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_o, index, 4'b0000};
            end else begin
              state_q        <= ALLOCATE;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {address_b[15:4], 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state_q        <= ALLOCATE;
            pmem_write_q   <= 1'b0;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= {address_b[15:4], 4'b0000};
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_address_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = line;

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hit_q, miss_q;
  logic        from_alloc_q;

  // The hit that completes a miss follows directly on an ALLOCATE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q        <= '0;
      miss_q       <= '0;
      from_alloc_q <= 1'b0;
    end else begin
      from_alloc_q <= (state_q == ALLOCATE);
      if (resp_b && !from_alloc_q && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      if ((state_q == IDLE) && req && !hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized traffic
// against a set-level cache model and a sparse backing-memory model.
module tb_dcache;
  localparam int NUM_SETS = 8;
  localparam int IW = $clog2(NUM_SETS);

  logic         clk = 1'b0;
  logic         reset;
  logic         read_b, write_b;
  logic [1:0]   wmask_b;
  logic [15:0]  address_b, wdata_b;
  logic         resp_b;
  logic [15:0]  rdata_b;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count, miss_count;

  dcache #(.NUM_SETS(NUM_SETS)) dut (
    .clk(clk), .reset(reset), .read_b(read_b), .write_b(write_b),
    .wmask_b(wmask_b), .address_b(address_b), .wdata_b(wdata_b),
    .resp_b(resp_b), .rdata_b(rdata_b), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what each set holds, and what physical memory holds per line address.
  bit           mvalid [NUM_SETS];
  bit           mdirty [NUM_SETS];
  int           mtag   [NUM_SETS];
  logic [127:0] mdata  [NUM_SETS];
  logic [127:0] mem    [int];
  int           m_hits, m_misses;

  logic [15:0]  last_rdata;
  logic [15:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp_hit, input int exp_miss);
`ifdef DCACHE_PERF_CNT_EN
    chk({name, " hit_count"}, 128'(hit_count), 128'(exp_hit));
    chk({name, " miss_count"}, 128'(miss_count), 128'(exp_miss));
`else
    chk({name, " hit_count"}, 128'(hit_count), 128'd0);
    chk({name, " miss_count"}, 128'(miss_count), 128'd0);
`endif
  endtask

  function automatic logic [127:0] get_line(input int la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
    return mem[la];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SETS; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic idle_cycle();
    read_b = 0; write_b = 0;
    pmem_resp = 1'($urandom_range(0, 1));
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("idle resp_b", 128'(resp_b), 128'd0);
    chk("idle rdata_b", 128'(rdata_b), 128'd0);
    chk("idle strobes", 128'({pmem_read, pmem_write}), 128'd0);
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] m, input logic [15:0] wd, input int lat);
    int s, tg, w, la;
    bit hit;
    logic [15:0] va;
    logic [127:0] line;
    s  = int'(a[3+IW:4]);
    tg = int'(a[15:4+IW]);
    w  = int'(a[3:1]);
    la = int'(a[15:4]);
    hit = mvalid[s] && (mtag[s] == tg);
    read_b = rd; write_b = wr; address_b = a; wmask_b = m; wdata_b = wd;
    pmem_resp = 0;
    if (!hit) begin
      m_misses++;
      @(negedge clk);
      chk("miss detect resp_b", 128'(resp_b), 128'd0);
      chk("miss detect strobes", 128'({pmem_read, pmem_write}), 128'd0);
      @(posedge clk); #1;
      if (mvalid[s] && mdirty[s]) begin
        va = 16'((mtag[s] << (4 + IW)) | (s << 4));
        for (int c = 1; c <= lat; c++) begin
          pmem_resp = (c == lat);
          @(negedge clk);
          chk("wb strobes", 128'({pmem_read, pmem_write}), 128'b01);
          chk("wb address", 128'(pmem_address), 128'(va));
          chk("wb data", pmem_wdata, mdata[s]);
          chk("wb resp_b", 128'(resp_b), 128'd0);
          last_wb_addr = pmem_address;
          last_wb_data = pmem_wdata;
          @(posedge clk); #1;
        end
        pmem_resp = 0;
        mem[int'(va >> 4)] = mdata[s];
      end
      line = get_line(la);
      for (int c = 1; c <= lat; c++) begin
        pmem_resp = (c == lat);
        pmem_rdata = line;
        @(negedge clk);
        chk("fill strobes", 128'({pmem_read, pmem_write}), 128'b10);
        chk("fill address", 128'(pmem_address), 128'({a[15:4], 4'b0000}));
        chk("fill resp_b", 128'(resp_b), 128'd0);
        @(posedge clk); #1;
      end
      pmem_resp = 0;
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mvalid[s] = 1; mdirty[s] = 0; mtag[s] = tg; mdata[s] = line;
    end else begin
      m_hits++;
    end
    @(negedge clk);
    chk("hit resp_b", 128'(resp_b), 128'd1);
    if (!wr) chk("hit rdata_b", 128'(rdata_b), 128'(mdata[s][w*16 +: 16]));
    chk("hit strobes", 128'({pmem_read, pmem_write}), 128'd0);
    last_rdata = rdata_b;
    @(posedge clk); #1;
    if (wr && m != 2'b00) begin
      if (m[0]) mdata[s][w*16 +: 8]     = wd[7:0];
      if (m[1]) mdata[s][w*16 + 8 +: 8] = wd[15:8];
      mdirty[s] = 1;
    end
    read_b = 0; write_b = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    read_b = 0; write_b = 0; pmem_resp = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    read_b = 0; write_b = 0; wmask_b = 0; address_b = 0; wdata_b = 0;
    pmem_rdata = '0; pmem_resp = 0;
    apply_reset();
    @(negedge clk);
    chk("reset resp_b", 128'(resp_b), 128'd0);
    chk("reset strobes", 128'({pmem_read, pmem_write}), 128'd0);
    chk("reset pmem_address", 128'(pmem_address), 128'd0);
    chk_cnt("reset", 0, 0);
    @(posedge clk); #1;

    // Cold read of a known line.
    mem[int'(16'h0123)] = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    do_req(1, 0, 16'h1236, 2'b11, 16'h0000, 3);
    chk("cold read literal", 128'(last_rdata), 128'h0004);
    chk_cnt("after cold read", 0, 1);
    idle_cycle();
    do_req(1, 0, 16'h1236, 2'b11, 16'h0000, 3);
    chk("repeat read literal", 128'(last_rdata), 128'h0004);
    chk_cnt("after repeat read", 1, 1);

    // High-byte write, then read back merged word.
    do_req(0, 1, 16'h1237, 2'b10, 16'hAB00, 3);
    do_req(1, 0, 16'h1236, 2'b11, 16'h0000, 3);
    chk("byte merge literal", 128'(last_rdata), 128'hAB04);

    // Conflict forces writeback of the dirty line.
    do_req(1, 0, 16'h1236 + 16'(NUM_SETS * 16), 2'b11, 16'h0000, 2);
    chk("wb addr literal", 128'(last_wb_addr), 128'h1230);
    chk("wb data literal", last_wb_data, 128'h0008_0007_0006_0005_AB04_0003_0002_0001);
    chk_cnt("after conflict", 3, 2);

    // Read and write together act as a write.
    do_req(1, 1, 16'h12B6, 2'b11, 16'h5A5A, 2);
    idle_cycle();
    do_req(1, 0, 16'h12B6, 2'b11, 16'h0000, 2);
    chk("both-high write literal", 128'(last_rdata), 128'h5A5A);

    // Reset in the middle of ALLOCATE.
    apply_reset();
    read_b = 1; address_b = 16'h4440; wmask_b = 2'b11;
    @(negedge clk);
    chk("pre-reset miss resp_b", 128'(resp_b), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre-reset alloc strobe", 128'(pmem_read), 128'd1);
    @(posedge clk); #1;
    reset = 1; pmem_resp = 1; read_b = 0; pmem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(posedge clk); #1;
    reset = 0; pmem_resp = 0;
    model_reset();
    @(negedge clk);
    chk("post-reset strobes", 128'({pmem_read, pmem_write}), 128'd0);
    chk("post-reset resp_b", 128'(resp_b), 128'd0);
    @(posedge clk); #1;
    do_req(1, 0, 16'h4440, 2'b11, 16'h0000, 2);
    chk_cnt("after reset re-read", 0, 1);

    // Randomized traffic over a few conflicting tags.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        int op, tsel;
        logic [15:0] a;
        logic [1:0]  msk;
        op   = $urandom_range(0, 2);
        tsel = $urandom_range(0, 2);
        a = 16'(((tsel == 0 ? 9'h024 : (tsel == 1 ? 9'h025 : 9'h1F3)) << 7)
                | ($urandom_range(0, NUM_SETS - 1) << 4) | $urandom_range(0, 15));
        msk = 2'($urandom_range(0, 3));
        do_req(op != 1, op != 0, a, msk, 16'($urandom), $urandom_range(1, 4));
      end
    end
    chk_cnt("end of random", m_hits, m_misses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
